// File: rtl/disp_pkg.sv
// Shared types, segment constants and index helpers for the display scan blocks.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        SCAN,
        BLANK,
        FAULT
    } state_t;

    // Bit offset of the 7-bit pattern for (src, digit) in the flattened source bus.
    function automatic int seg_slice(input int src, input int digit, input int num_digits);
        return (src * num_digits + digit) * 7;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..SCAN_DIV-1 slot counter; tick marks the last cycle of each slot.
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == TC);

endmodule

// File: rtl/disp_scan_mux.sv
// Multi-source 7-segment scan multiplexer with blanking on mode change and a
// dash fault pattern for illegal or disabled sources.
module disp_scan_mux #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int SEL_W      = 2,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_W-1:0]                mode,
    input  logic [NUM_SRC-1:0]              src_en,
    input  logic [NUM_SRC*NUM_DIGITS*7-1:0] src_seg,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [SEL_W-1:0]                active_mode,
    output logic                            fault
);

    import disp_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W  = $clog2(BLANK_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'(BLANK_CYC - 1);

    state_t                  state, state_nxt;
    logic [BC_W-1:0]         blank_cnt, blank_cnt_nxt;
    logic [SEL_W-1:0]        blank_mode, blank_mode_nxt;
    logic                    blank_vld, blank_vld_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [SEL_W-1:0]        active_mode_nxt;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    fault_nxt;

    logic                    mode_legal;
    logic [6:0]              cur_pat;
    logic [NUM_DIGITS-1:0]   an_digit;
    logic                    presc_clr;
    logic                    tick;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_comb begin
        mode_legal = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (mode == SEL_W'(s)) mode_legal = src_en[s];
        end
    end

    always_comb begin
        cur_pat = SEG_BLANK;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (active_mode == SEL_W'(s) && idx == IDX_W'(d))
                    cur_pat = src_seg[seg_slice(s, d, NUM_DIGITS) +: 7];
            end
        end
    end

    always_comb begin
        an_digit = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) an_digit[d] = 1'b0;
        end
    end

    assign presc_clr = (state != SCAN);

    always_comb begin
        state_nxt       = state;
        blank_cnt_nxt   = blank_cnt;
        blank_mode_nxt  = blank_mode;
        blank_vld_nxt   = blank_vld;
        idx_nxt         = idx;
        active_mode_nxt = active_mode;
        seg_nxt         = seg;
        an_nxt          = an;
        fault_nxt       = fault;

        case (state)
            SCAN: begin
                seg_nxt = cur_pat;
                an_nxt  = an_digit;
                if (!mode_legal) begin
                    state_nxt = FAULT;
                end else if (mode != active_mode) begin
                    state_nxt      = BLANK;
                    blank_cnt_nxt  = '0;
                    blank_mode_nxt = mode;
                    blank_vld_nxt  = 1'b1;
                end else if (tick) begin
                    idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            BLANK: begin
                seg_nxt = SEG_BLANK;
                an_nxt  = '1;
                if (!mode_legal) begin
                    state_nxt = FAULT;
                end else if (blank_vld && mode != blank_mode) begin
                    // a second mode change restarts the blanking window
                    blank_cnt_nxt  = '0;
                    blank_mode_nxt = mode;
                end else if (blank_cnt == BLANK_LAST) begin
                    state_nxt       = SCAN;
                    active_mode_nxt = mode;
                    idx_nxt         = '0;
                    blank_cnt_nxt   = '0;
                end else begin
                    blank_cnt_nxt  = blank_cnt + 1'b1;
                    blank_mode_nxt = mode;
                    blank_vld_nxt  = 1'b1;
                end
            end
            FAULT: begin
                seg_nxt   = SEG_DASH;
                an_nxt    = '0;
                fault_nxt = 1'b1;
                if (mode_legal) begin
                    state_nxt      = BLANK;
                    fault_nxt      = 1'b0;
                    blank_cnt_nxt  = '0;
                    blank_mode_nxt = mode;
                    blank_vld_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            blank_cnt   <= '0;
            blank_mode  <= '0;
            blank_vld   <= 1'b0;
            idx         <= '0;
            active_mode <= '0;
            seg         <= SEG_BLANK;
            an          <= '1;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            blank_cnt   <= blank_cnt_nxt;
            blank_mode  <= blank_mode_nxt;
            blank_vld   <= blank_vld_nxt;
            idx         <= idx_nxt;
            active_mode <= active_mode_nxt;
            seg         <= seg_nxt;
            an          <= an_nxt;
            fault       <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux with SCAN_DIV=4, BLANK_CYC=2, four sources of four digits.
module tb_disp_scan_mux;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic [3:0]   src_en;
    logic [111:0] src_seg;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic [1:0]   active_mode;
    logic         fault;

    int errors = 0;
    int checks = 0;

    disp_scan_mux #(
        .NUM_SRC    (4),
        .NUM_DIGITS (4),
        .SEL_W      (2),
        .SCAN_DIV   (4),
        .BLANK_CYC  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .src_en      (src_en),
        .src_seg     (src_seg),
        .seg         (seg),
        .an          (an),
        .active_mode (active_mode),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int s, input int d);
        logic [1:0] ss;
        logic [1:0] dd;
        ss = 2'(s);
        dd = 2'(d);
        return {ss, dd, 3'b101};
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 2'd1;
        src_en = 4'b1111;
        step();
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (active_mode !== 2'd0) begin errors++; $display("FAIL reset_active_mode: got %0d want 0", active_mode); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        rst = 1'b0;
    endtask

    task automatic test_startup_scan();
        for (int c = 0; c < 3; c++) begin
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL start_blank c%0d: an got %b want 1111", c, an); end
            if (c < 2) step();
        end
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                checks++; if (an !== an_of(d) || seg !== pat(1, d)) begin
                    errors++; $display("FAIL scan d%0d k%0d: an=%b seg=%h want an=%b seg=%h", d, k, an, seg, an_of(d), pat(1, d));
                end
            end
        end
        checks++; if (active_mode !== 2'd1) begin errors++; $display("FAIL scan_active_mode: got %0d want 1", active_mode); end
        step();
        checks++; if (an !== 4'b1110 || seg !== pat(1, 0)) begin
            errors++; $display("FAIL scan_wrap: an=%b seg=%h want an=1110 seg=%h", an, seg, pat(1, 0));
        end
    endtask

    task automatic test_mode_change();
        mode = 2'd2;
        step();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin
                errors++; $display("FAIL chg_blank c%0d: an=%b seg=%h want an=1111 seg=7f", c, an, seg);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (an !== 4'b1110 || seg !== pat(2, 0)) begin
                errors++; $display("FAIL chg_digit0 k%0d: an=%b seg=%h want an=1110 seg=%h", k, an, seg, pat(2, 0));
            end
        end
        checks++; if (active_mode !== 2'd2) begin errors++; $display("FAIL chg_active_mode: got %0d want 2", active_mode); end
        step();
        checks++; if (an !== 4'b1101 || seg !== pat(2, 1)) begin
            errors++; $display("FAIL chg_digit1: an=%b seg=%h want an=1101 seg=%h", an, seg, pat(2, 1));
        end
    endtask

    task automatic test_fault();
        mode = 2'd3;
        src_en = 4'b0111;
        step();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (seg !== 7'b0111111 || an !== 4'b0000 || fault !== 1'b1) begin
                errors++; $display("FAIL fault_dash c%0d: seg=%h an=%b fault=%b want seg=3f an=0000 fault=1", c, seg, an, fault);
            end
        end
        checks++; if (active_mode !== 2'd2) begin errors++; $display("FAIL fault_active_mode: got %0d want 2", active_mode); end
        src_en = 4'b1111;
        step();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin
                errors++; $display("FAIL fault_blank c%0d: an=%b seg=%h want an=1111 seg=7f", c, an, seg);
            end
        end
        step();
        checks++; if (an !== 4'b1110 || seg !== pat(3, 0) || active_mode !== 2'd3) begin
            errors++; $display("FAIL fault_resume: an=%b seg=%h am=%0d want an=1110 seg=%h am=3", an, seg, active_mode, pat(3, 0));
        end
    endtask

    task automatic test_blank_toggle();
        mode = 2'd1;
        step();
        mode = 2'd2;
        step();
        mode = 2'd1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin
                errors++; $display("FAIL toggle_blank c%0d: an=%b seg=%h want an=1111 seg=7f", c, an, seg);
            end
        end
        step();
        checks++; if (an !== 4'b1110 || seg !== pat(1, 0) || active_mode !== 2'd1) begin
            errors++; $display("FAIL toggle_resume: an=%b seg=%h am=%0d want an=1110 seg=%h am=1", an, seg, active_mode, pat(1, 0));
        end
    endtask

    task automatic test_tick_collision();
        step();
        step();
        mode = 2'd2;
        step();
        checks++; if (an !== 4'b1110 || seg !== pat(1, 0)) begin
            errors++; $display("FAIL tick_col_last: an=%b seg=%h want an=1110 seg=%h", an, seg, pat(1, 0));
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL tick_col_blank c%0d: an=%b want 1111", c, an); end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (an !== 4'b1110 || seg !== pat(2, 0)) begin
                errors++; $display("FAIL tick_col_digit0 k%0d: an=%b seg=%h want an=1110 seg=%h", k, an, seg, pat(2, 0));
            end
        end
        step();
        checks++; if (an !== 4'b1101 || seg !== pat(2, 1)) begin
            errors++; $display("FAIL tick_col_digit1: an=%b seg=%h want an=1101 seg=%h", an, seg, pat(2, 1));
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (seg !== 7'h7F || an !== 4'b1111 || active_mode !== 2'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL async_reset: seg=%h an=%b am=%0d fault=%b want seg=7f an=1111 am=0 fault=0", seg, an, active_mode, fault);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_blank c%0d: an=%b want 1111", c, an); end
            step();
        end
        checks++; if (an !== 4'b1110 || seg !== pat(2, 0) || active_mode !== 2'd2) begin
            errors++; $display("FAIL rst_resume: an=%b seg=%h am=%0d want an=1110 seg=%h am=2", an, seg, active_mode, pat(2, 0));
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                src_seg[(s*4 + d)*7 +: 7] = pat(s, d);
            end
        end
        rst = 1'b1;
        mode = 2'd0;
        src_en = 4'b1111;
        test_reset();
        test_startup_scan();
        test_mode_change();
        test_fault();
        test_blank_toggle();
        test_tick_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Parametrised multi-source 7-segment display multiplexer with built-in digit scanning. Successor to the team's single-digit display mux.
- Selects one of NUM_SRC display sources by mode and time-multiplexes its NUM_DIGITS digit patterns onto the shared seg/an pins.
- Inserts a blanking interval on every mode change to suppress ghosting.
- Shows an all-digit dash fault pattern when mode is illegal or selects a disabled source.
- Sits between the per-mode display formatters and the board 7-segment pins.

Parameters:
- NUM_SRC, 4: number of selectable display sources.
- NUM_DIGITS, 4: number of digits/anodes.
- SEL_W, 2: width of mode; must satisfy 2**SEL_W >= NUM_SRC.
- SCAN_DIV, 100000: clk cycles per digit slot; must be >= 2.
- BLANK_CYC, 1000: cycles all anodes are off after a mode change; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  SEL_W  requested source index.
- src_en  in  NUM_SRC  bit s = 1 marks source s as legal.
- src_seg  in  NUM_SRC*NUM_DIGITS*7  segment patterns, active-low. Source s, digit d occupies bits [(s*NUM_DIGITS+d)*7 +: 7].
- seg  out  7  segment drive, active-low, registered.
- an  out  NUM_DIGITS  anode drive, active-low, registered.
- active_mode  out  SEL_W  source currently displayed, registered.
- fault  out  1  high while in the FAULT state, registered.

Behaviour:
- Reset values: seg=7'h7F, an=all ones, active_mode=0, fault=0. Internally: state=BLANK, blank counter=0, prescaler=0, digit index=0.
- Definition: "legal(m)" = (m < NUM_SRC) && src_en[m].
- State SCAN:
  - Prescaler counts 0..SCAN_DIV-1 and wraps. "tick" is asserted in the cycle the prescaler equals SCAN_DIV-1.
  - On tick, digit index advances; it wraps from NUM_DIGITS-1 to 0.
  - Each cycle: seg <= pattern(active_mode, idx) and an <= ~(1<<idx). Outputs lag the index by one cycle.
  - If mode != active_mode and legal(mode): go to BLANK. This has priority over a tick in the same cycle.
  - If !legal(mode) (including src_en[active_mode] dropping): go to FAULT.
- State BLANK:
  - an <= all ones, seg <= 7'h7F, and the blank counter increments.
  - When the counter reaches BLANK_CYC-1 and legal(mode): active_mode <= mode, prescaler <= 0, idx <= 0, counter <= 0, go to SCAN.
  - If mode differs from the value sampled when BLANK was entered, the counter restarts from 0.
  - If !legal(mode) at any point: go to FAULT.
- State FAULT:
  - seg <= 7'b0111111 (dash), an <= all zeros (all digits on), fault <= 1.
  - When legal(mode): fault <= 0, counter <= 0, go to BLANK. SCAN is never entered directly from FAULT.
- Timing:
  - Mode-change latency: the first new-source digit appears BLANK_CYC+1 cycles after the mode change is sampled.
  - From reset release with legal mode: the first digit-0 pattern appears at cycle BLANK_CYC+1.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). Pin glitches during reset are acceptable.
- Width rules:
  - Prescaler width is $clog2(SCAN_DIV).
  - Index width is $clog2(NUM_DIGITS), minimum 1.
  - Blank counter width is $clog2(BLANK_CYC+1).
  - Counters never exceed their terminal values.
- src_seg is sampled live each cycle; no latching of pattern data.

Decomposition:
- Package disp_pkg holds:
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'b0111111.
  - State enum {SCAN, BLANK, FAULT}.
  - Function seg_slice(src, digit) for the index arithmetic.
- One sub-module, scan_prescaler: parametrised by SCAN_DIV, with inputs clk, rst, clr and output tick. Reused by other display blocks.

Test Plan (SCAN_DIV=4, BLANK_CYC=2, NUM_SRC=4, NUM_DIGITS=4; digit pattern = {src,digit} encoded):
1. Reset, mode=1, src_en=4'b1111 -> an=4'b1111 for 3 cycles. Then an cycles 1110, 1101, 1011, 0111, 4 clk each, with seg = src1 digit patterns. active_mode=1.
2. Mid-scan mode 1->2 -> an=4'b1111 for 2 cycles. Then an=1110 with src2 digit0. idx restarts at 0 and active_mode=2 from that cycle.
3. mode=3 with src_en=4'b0111 -> next cycle seg=7'b0111111, an=4'b0000, fault=1. Restoring src_en[3]=1 -> 2 blank cycles, then src3 digit0.
4. Mode toggles 1->2->1 within the blank window -> blank counter restarts. SCAN resumes with active_mode=1, never showing src2.
5. Mode change in the same cycle as a tick -> BLANK entered; idx not advanced on the displayed output.
6. rst pulsed mid-scan (between clock edges) -> seg=7'h7F, an=4'b1111 immediately. Scan restarts at digit 0 after BLANK.
